// File: rtl/mem_ctrl_pkg.sv
// Shared types and codes for the byte-wide RAM controller.
// Holds the controller state encoding, the request owner encoding,
// the mem_len byte-count codes and a helper that folds the illegal length
// code onto a full word.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_e;

   // mem_len carries (bytes - 1)
   localparam logic [1:0] LEN_1B = 2'd0;
   localparam logic [1:0] LEN_2B = 2'd1;
   localparam logic [1:0] LEN_4B = 2'd3;

   // The unused code 2 is treated as a full-word access
   function automatic logic [1:0] norm_len(input logic [1:0] len);
      return (len == 2'd2) ? LEN_4B : len;
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: sole master of a byte-wide single-port RAM, shared between
// instruction fetch (IF) and the MEM stage. Each request is broken into
// 1/2/4 byte beats; read bytes are assembled little-endian into a word.
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   if_req/if_addr/if_flush  fetch request (always 4 bytes) and branch flush
//   mem_req/mem_we/mem_len/mem_addr/mem_wdata  load/store request
//   ram_din/ram_addr/ram_wr/ram_dout           RAM port (read data 1 cycle late)
//   if_done/if_data, mem_done/mem_rdata        completion pulses and data
//   stallreq_if/stallreq_mem                   hold requests to pipeline control
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [1:0]        mem_len,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [7:0]        ram_din,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wr,
   output logic [7:0]        ram_dout,
   output logic              if_done,
   output logic [DATA_W-1:0] if_data,
   output logic              mem_done,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              stallreq_if,
   output logic              stallreq_mem
);

   state_e              state_q;
   owner_e              owner_q;
   logic                we_q;
   logic [1:0]          len_q;
   logic [ADDR_W-1:0]   base_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [2:0]          cnt_q;
   logic [DATA_W-1:0]   buf_q;
   logic                kill_q;
   logic                if_done_q;
   logic                mem_done_q;
   logic [DATA_W-1:0]   if_data_q;
   logic [DATA_W-1:0]   mem_rdata_q;

   logic [DATA_W-1:0]   buf_d;
   logic                kill_d;
   logic                last_beat;
   logic [1:0]          cap_lane;

   always_comb begin
      // Read data for the address issued at cnt=k arrives while cnt=k+1
      cap_lane = cnt_q[1:0] - 2'd1;
      buf_d    = buf_q;
      if (state_q == ST_BUSY && !we_q && cnt_q != 3'd0)
         buf_d[{cap_lane, 3'b000} +: 8] = ram_din;
      last_beat = we_q ? (cnt_q == {1'b0, len_q})
                       : (cnt_q == ({1'b0, len_q} + 3'd1));
      kill_d = kill_q | (if_flush && owner_q == OWN_IF && state_q != ST_IDLE);
   end

   // RAM port is decoded purely from registered state
   always_comb begin
      ram_wr   = (state_q == ST_BUSY) && we_q;
      ram_addr = '0;
      ram_dout = 8'h00;
      if (state_q == ST_BUSY && cnt_q <= {1'b0, len_q})
         ram_addr = base_q + ADDR_W'(cnt_q);
      if (ram_wr)
         ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_IF;
         we_q        <= 1'b0;
         len_q       <= LEN_1B;
         base_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= 3'd0;
         buf_q       <= '0;
         kill_q      <= 1'b0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         if_data_q   <= '0;
         mem_rdata_q <= '0;
      end else begin
         if_done_q  <= 1'b0;
         mem_done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               kill_q <= 1'b0;
               cnt_q  <= 3'd0;
               buf_q  <= '0;
               // MEM belongs to the older instruction, so it wins
               if (mem_req) begin
                  owner_q <= OWN_MEM;
                  we_q    <= mem_we;
                  len_q   <= norm_len(mem_len);
                  base_q  <= mem_addr;
                  wdata_q <= mem_wdata;
                  state_q <= ST_BUSY;
               end else if (if_req && !if_flush) begin
                  owner_q <= OWN_IF;
                  we_q    <= 1'b0;
                  len_q   <= LEN_4B;
                  base_q  <= if_addr;
                  wdata_q <= '0;
                  state_q <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               buf_q  <= buf_d;
               kill_q <= kill_d;
               cnt_q  <= cnt_q + 3'd1;
               if (last_beat) begin
                  state_q <= ST_DONE;
                  if (owner_q == OWN_IF) begin
                     // A flushed fetch still finishes on the RAM, silently
                     if_done_q <= ~kill_d;
                     if (!kill_d)
                        if_data_q <= buf_d;
                  end else begin
                     mem_done_q  <= 1'b1;
                     mem_rdata_q <= buf_d;
                  end
               end
            end
            ST_DONE: begin
               kill_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // A flush landing in the done cycle itself must still hide the pulse
   assign if_done      = if_done_q & ~if_flush;
   assign if_data      = if_data_q;
   assign mem_done     = mem_done_q;
   assign mem_rdata    = mem_rdata_q;
   assign stallreq_if  = if_req & ~if_done;
   assign stallreq_mem = mem_req & ~mem_done;

endmodule
